// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between the CPU
// load/store path and the I/O requester; each access runs IDLE -> ISSUE -> CAPTURE.
module mem_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              io_req,
    input  logic              io_we,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [DATA_W-1:0] io_wdata,
    output logic              io_ack,
    output logic [DATA_W-1:0] io_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              cpuAck_q, cpuAck_d;
    logic              ioAck_q, ioAck_d;
    logic [DATA_W-1:0] cpuRdata_q, cpuRdata_d;
    logic [DATA_W-1:0] ioRdata_q, ioRdata_d;

    logic effCpu;
    logic effIo;
    logic anyReq;
    logic grantIo;

    // A port is masked in its own ack cycle so a held req is not served twice.
    assign effCpu  = cpu_req & ~cpuAck_q;
    assign effIo   = io_req & ~ioAck_q;
    assign anyReq  = effCpu | effIo;
    assign grantIo = effIo & (~effCpu | ~last_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (anyReq) state_d = ISSUE;
            ISSUE:   state_d = CAPTURE;
            CAPTURE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        owner_d    = owner_q;
        last_d     = last_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cpuAck_d   = 1'b0;
        ioAck_d    = 1'b0;
        cpuRdata_d = cpuRdata_q;
        ioRdata_d  = ioRdata_q;
        if (state_q == IDLE && anyReq) begin
            owner_d = grantIo;
            we_d    = grantIo ? io_we    : cpu_we;
            addr_d  = grantIo ? io_addr  : cpu_addr;
            wdata_d = grantIo ? io_wdata : cpu_wdata;
        end
        if (state_q == CAPTURE) begin
            if (!we_q) begin
                if (owner_q) ioRdata_d  = mem_rdata;
                else         cpuRdata_d = mem_rdata;
            end
            if (owner_q) ioAck_d  = 1'b1;
            else         cpuAck_d = 1'b1;
            last_d = owner_q;
        end
    end

    // last resets to IO so the CPU wins the first tie after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cpuAck_q   <= 1'b0;
            ioAck_q    <= 1'b0;
            cpuRdata_q <= '0;
            ioRdata_q  <= '0;
        end else begin
            owner_q    <= owner_d;
            last_q     <= last_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cpuAck_q   <= cpuAck_d;
            ioAck_q    <= ioAck_d;
            cpuRdata_q <= cpuRdata_d;
            ioRdata_q  <= ioRdata_d;
        end
    end

    always_comb begin
        mem_we    = (state_q == ISSUE) & we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        cpu_ack   = cpuAck_q;
        io_ack    = ioAck_q;
        cpu_rdata = cpuRdata_q;
        io_rdata  = ioRdata_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: drivers queue expected accesses, a monitor
// checks every ack against a flat reference memory.
module tb_mem_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cpu_req = 1'b0, cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              io_req = 1'b0, io_we = 1'b0;
    logic [ADDR_W-1:0] io_addr = '0;
    logic [DATA_W-1:0] io_wdata = '0;
    logic              io_ack;
    logic [DATA_W-1:0] io_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    int testCount = 0;
    int failCount = 0;

    req_t              cpuQ[$];
    req_t              ioQ[$];
    logic [ADDR_W-1:0] abortedAddr[$];
    logic [DATA_W-1:0] abortedData[$];
    logic [DATA_W-1:0] modelMem[int];
    logic [DATA_W-1:0] expCpuRdata = '0;
    logic [DATA_W-1:0] expIoRdata = '0;
    logic              prevCpuAck = 1'b0;
    logic              prevIoAck = 1'b0;

    logic [DATA_W-1:0] tbRam[0:(1<<ADDR_W)-1];
    logic              ramLoaded = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_ack(io_ack), .io_rdata(io_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [DATA_W-1:0] initWord(input int a);
        if (a == 5) return 16'h1234;
        return 16'(a * 37) ^ 16'h5A5A;
    endfunction

    function automatic logic [DATA_W-1:0] modelRead(input int a);
        if (modelMem.exists(a)) return modelMem[a];
        return initWord(a);
    endfunction

    // Behavioural single-port RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (!ramLoaded) begin
            for (int i = 0; i < (1 << ADDR_W); i++) tbRam[i] <= initWord(i);
            ramLoaded <= 1'b1;
        end else if (mem_we) begin
            tbRam[mem_addr] <= mem_wdata;
        end
        mem_rdata <= tbRam[mem_addr];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic scoreAck(input bit port);
        req_t item;
        checkOutput(port ? "io_ack_width" : "cpu_ack_width", port ? prevIoAck : prevCpuAck, 0);
        if ((port ? ioQ.size() : cpuQ.size()) == 0) begin
            testCount++;
            failCount++;
            $display("[TB] FAIL %s_unexpected_ack: actual ack with no request pending, required none",
                     port ? "io" : "cpu");
        end else begin
            item = port ? ioQ.pop_front() : cpuQ.pop_front();
            if (item.we) modelMem[int'(item.addr)] = item.data;
            else if (port) expIoRdata = modelRead(int'(item.addr));
            else expCpuRdata = modelRead(int'(item.addr));
            checkOutput("cpu_rdata", cpu_rdata, expCpuRdata);
            checkOutput("io_rdata", io_rdata, expIoRdata);
        end
    endtask

    // Monitor: reset clears the expected rdata, each ack retires one queued access.
    always @(negedge clk) begin
        if (reset) begin
            expCpuRdata = '0;
            expIoRdata  = '0;
        end else begin
            while (abortedAddr.size() > 0) modelMem[int'(abortedAddr.pop_front())] = abortedData.pop_front();
            if (cpu_ack && io_ack) begin
                testCount++;
                failCount++;
                $display("[TB] FAIL ack_overlap: actual both acks high, required at most one");
            end
            if (cpu_ack) scoreAck(1'b0);
            if (io_ack) scoreAck(1'b1);
        end
        prevCpuAck = cpu_ack;
        prevIoAck  = io_ack;
    end

    task automatic setPort(input bit port, input logic req, input logic we,
                           input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        if (port) begin
            io_req = req; io_we = we; io_addr = addr; io_wdata = data;
        end else begin
            cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = data;
        end
    endtask

    task automatic pushExpect(input bit port, input logic we, input logic [ADDR_W-1:0] addr,
                              input logic [DATA_W-1:0] data);
        req_t item;
        item.we = we; item.addr = addr; item.data = data;
        if (port) ioQ.push_back(item);
        else cpuQ.push_back(item);
    endtask

    function automatic logic ackFor(input bit port);
        return port ? io_ack : cpu_ack;
    endfunction

    task automatic checkResetOutputs(input string name);
        checkOutput({name, "_cpu_ack"}, cpu_ack, 0);
        checkOutput({name, "_io_ack"}, io_ack, 0);
        checkOutput({name, "_cpu_rdata"}, cpu_rdata, 0);
        checkOutput({name, "_io_rdata"}, io_rdata, 0);
        checkOutput({name, "_mem_addr"}, mem_addr, 0);
        checkOutput({name, "_mem_we"}, mem_we, 0);
        checkOutput({name, "_mem_wdata"}, mem_wdata, 0);
    endtask

    // Uncontended access: ack three cycles after the request cycle.
    task automatic applyStimulus(input bit port, input logic we, input logic [ADDR_W-1:0] addr,
                                 input logic [DATA_W-1:0] data, input string name);
        int ackK = 0;
        int weCount = 0;
        @(negedge clk);
        setPort(port, 1'b1, we, addr, data);
        pushExpect(port, we, addr, data);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (mem_we) weCount++;
            if (k == 1) begin
                checkOutput({name, "_mem_addr"}, mem_addr, addr);
                if (we) checkOutput({name, "_mem_wdata"}, mem_wdata, data);
            end
            if (ackFor(port)) begin
                ackK = k;
                break;
            end
        end
        setPort(port, 1'b0, 1'b0, '0, '0);
        checkOutput({name, "_ack_latency"}, ackK, 3);
        checkOutput({name, "_mem_we_pulses"}, weCount, we ? 1 : 0);
    endtask

    task automatic tieTest(input string name);
        int cpuK = 0;
        int ioK = 0;
        @(negedge clk);
        setPort(1'b0, 1'b1, 1'b0, 10'h005, '0);
        setPort(1'b1, 1'b1, 1'b0, 10'h3FF, '0);
        pushExpect(1'b0, 1'b0, 10'h005, '0);
        pushExpect(1'b1, 1'b0, 10'h3FF, '0);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (cpu_ack && cpuK == 0) begin cpuK = k; setPort(1'b0, 1'b0, 1'b0, '0, '0); end
            if (io_ack && ioK == 0) begin ioK = k; setPort(1'b1, 1'b0, 1'b0, '0, '0); end
            if (cpuK != 0 && ioK != 0) break;
        end
        setPort(1'b0, 1'b0, 1'b0, '0, '0);
        setPort(1'b1, 1'b0, 1'b0, '0, '0);
        checkOutput({name, "_cpu_ack_cycle"}, cpuK, 3);
        checkOutput({name, "_io_ack_cycle"}, ioK, 6);
    endtask

    // Both reqs held: acks every 3 cycles alternating, CPU first after an IO service.
    task automatic heldTest();
        int expCpu, expIo;
        @(negedge clk);
        setPort(1'b0, 1'b1, 1'b0, 10'h007, '0);
        setPort(1'b1, 1'b1, 1'b0, 10'h3FF, '0);
        for (int i = 0; i < 4; i++) pushExpect(1'b0, 1'b0, 10'h007, '0);
        for (int i = 0; i < 3; i++) pushExpect(1'b1, 1'b0, 10'h3FF, '0);
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            expCpu = (k % 3 == 0 && k <= 21 && ((k / 3) % 2) == 1) ? 1 : 0;
            expIo  = (k % 3 == 0 && k <= 21 && ((k / 3) % 2) == 0) ? 1 : 0;
            checkOutput($sformatf("held_cpu_ack_k%0d", k), cpu_ack, expCpu);
            checkOutput($sformatf("held_io_ack_k%0d", k), io_ack, expIo);
            if (k == 20) begin
                setPort(1'b0, 1'b0, 1'b0, '0, '0);
                setPort(1'b1, 1'b0, 1'b0, '0, '0);
            end
        end
    endtask

    task automatic randomPort(input bit port, input int n);
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                ackK;
        for (int t = 0; t < n; t++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            @(negedge clk);
            we   = 1'($urandom_range(0, 1));
            addr = ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom_range(0, 15));
            data = 16'($urandom);
            setPort(port, 1'b1, we, addr, data);
            pushExpect(port, we, addr, data);
            ackK = 0;
            for (int k = 1; k <= 12; k++) begin
                @(negedge clk);
                if (ackFor(port)) begin
                    ackK = k;
                    break;
                end
            end
            setPort(port, 1'b0, 1'b0, '0, '0);
            checkOutput(port ? "rand_io_latency_ok" : "rand_cpu_latency_ok",
                        (ackK >= 3 && ackK <= 6) ? 1 : 0, 1);
        end
    endtask

    // Abort an access by asserting reset for two cycles while it sits in CAPTURE.
    task automatic abortInCapture(input bit port, input logic we, input logic [ADDR_W-1:0] addr,
                                  input logic [DATA_W-1:0] data, input string name);
        @(negedge clk);
        setPort(port, 1'b1, we, addr, data);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        setPort(port, 1'b0, 1'b0, '0, '0);
        if (we) begin
            abortedAddr.push_back(addr);
            abortedData.push_back(data);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        checkResetOutputs(name);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checkOutput($sformatf("%s_no_ack_k%0d", name, k), ackFor(port), 0);
            checkOutput($sformatf("%s_rdata_k%0d", name, k), port ? io_rdata : cpu_rdata, 0);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: actual simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checkResetOutputs("reset");

        applyStimulus(1'b0, 1'b0, 10'h005, '0, "cpu_read");
        checkOutput("cpu_read_value", cpu_rdata, 16'h1234);

        applyStimulus(1'b1, 1'b1, 10'h3FF, 16'hBEEF, "io_write");
        applyStimulus(1'b1, 1'b0, 10'h3FF, '0, "io_read");
        checkOutput("io_read_value", io_rdata, 16'hBEEF);
        checkOutput("cpu_rdata_kept", cpu_rdata, 16'h1234);

        tieTest("tie");
        heldTest();

        fork
            randomPort(1'b0, 25);
            randomPort(1'b1, 25);
        join

        abortInCapture(1'b0, 1'b0, 10'h005, '0, "abort_cpu_read");
        tieTest("tie_after_reset");
        abortInCapture(1'b1, 1'b1, 10'h02A, 16'hCAFE, "abort_io_write");
        applyStimulus(1'b1, 1'b0, 10'h02A, '0, "io_read_after_abort");
        checkOutput("io_read_after_abort_value", io_rdata, 16'hCAFE);

        repeat (5) @(negedge clk);
        checkOutput("cpu_queue_drained", cpuQ.size(), 0);
        checkOutput("io_queue_drained", ioQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
